// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
// Module   : key_filter
// Purpose  : Conditions a raw, bouncing, active-low push-button into clean
//            one-cycle press / release / long-press pulses and a debounced
//            level. The press pulse feeds the downstream edge/pulse FSM.
// Ports    : i_sys_clk       - system clock, rising edge
//            i_rst_n         - asynchronous active-low reset
//            i_key_n         - raw asynchronous button, low = pressed
//            o_press_pulse   - one-cycle pulse on an accepted press
//            o_release_pulse - one-cycle pulse on an accepted release
//            o_long_pulse    - one-cycle pulse once per press at LONG_CYCLES
//            o_key_level     - debounced level, 1 = pressed
// Revision : 1.0  initial release
// ============================================================================
module key_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse,
  output logic o_key_level
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              long_done, long_done_nxt;
  logic              sync1, sync2;
  logic              key_s;
  logic              press_nxt, release_nxt, long_nxt, level_nxt;

  // Two-flop synchronizer; idle (released) value is 1.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_key_n;
      sync2 <= sync1;
    end
  end

  assign key_s = ~sync2;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      long_done       <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_long_pulse    <= 1'b0;
      o_key_level     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      long_done       <= long_done_nxt;
      o_press_pulse   <= press_nxt;
      o_release_pulse <= release_nxt;
      o_long_pulse    <= long_nxt;
      o_key_level     <= level_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    long_done_nxt = long_done;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_FILT;
          cnt_nxt   = '0;
        end
      end

      PRESS_FILT: begin
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt     = PRESSED;
          cnt_nxt       = '0;
          long_done_nxt = 1'b0;
          press_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      PRESSED: begin
        // A release sample takes priority over the long threshold.
        if (!key_s) begin
          state_nxt = RELEASE_FILT;
          cnt_nxt   = '0;
        end else if (!long_done && (cnt == LONG_LAST)) begin
          long_nxt      = 1'b1;
          long_done_nxt = 1'b1;
        end else if (!long_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RELEASE_FILT: begin
        // Returning to PRESSED keeps long_done so one press gives one long pulse.
        if (key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Level is registered from the next state so it moves with the pulses.
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_FILT);
  end

endmodule
`default_nettype wire
